axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all AR channels.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all R channels.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_axi_araddr  input  2*ADDR_WIDTH  per-requester read address; index 0 in low slice.
REQ-006 s_axi_arlen / s_axi_arsize / s_axi_arburst  input  2*8 / 2*3 / 2*2  per-requester burst attributes.
REQ-007 s_axi_arvalid  input  2  per-requester AR valid.
REQ-008 s_axi_arready  output  2  per-requester AR ready.
REQ-009 s_axi_rdata / s_axi_rresp  output  2*DATA_WIDTH / 2*2  per-requester read data and response.
REQ-010 s_axi_rlast / s_axi_rvalid  output  2 / 2  per-requester last-beat and valid.
REQ-011 s_axi_rready  input  2  per-requester R ready.
REQ-012 m_axi_araddr / m_axi_arlen / m_axi_arsize / m_axi_arburst  output  ADDR_WIDTH / 8 / 3 / 2  to shared slave.
REQ-013 m_axi_arvalid  output  1; m_axi_arready  input  1.
REQ-014 m_axi_rdata / m_axi_rresp / m_axi_rlast / m_axi_rvalid  input  DATA_WIDTH / 2 / 1 / 1  from shared slave.
REQ-015 m_axi_rready  output  1.
REQ-016 grant_id  output  1  index of the owning requester; valid when busy=1.
REQ-017 busy  output  1  high in ADDR and DATA states.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one outstanding read burst at any time.
REQ-019 IDLE: when any s_axi_arvalid bit is high, grant SHALL be registered and FSM SHALL move to ADDR on the next edge.
REQ-020 Arbitration: round-robin; with both requesting, the requester not granted last wins; with one requesting, it wins.
REQ-021 last-grant pointer SHALL update on the edge a grant is registered.
REQ-022 ADDR: m_axi_ar* SHALL equal the granted requester's ar* fields; m_axi_arvalid SHALL equal its s_axi_arvalid.
REQ-023 ADDR: s_axi_arready[grant_id] SHALL equal m_axi_arready; the other arready bit SHALL be 0.
REQ-024 ADDR -> DATA on m_axi_arvalid & m_axi_arready; grant held until that handshake, never preempted.
REQ-025 DATA: s_axi_r*[grant_id] SHALL equal m_axi_r*; m_axi_rready SHALL equal s_axi_rready[grant_id]; m_axi_arvalid=0.
REQ-026 DATA -> IDLE on m_axi_rvalid & m_axi_rready & m_axi_rlast.
REQ-027 Non-granted requester SHALL see arready=0 and rvalid=0 in every state; IDLE drives all s-side arready/rvalid and m_axi_arvalid/m_axi_rready to 0.
REQ-028 Grant latency: arvalid sampled high in IDLE at edge N yields m_axi_arvalid=1 in cycle N+1; no combinational arvalid-to-arvalid path.
REQ-029 Turnaround: the cycle after the last-beat handshake is IDLE; minimum 2 cycles between consecutive AR handshakes on the m side.
REQ-030 arlen=0 (single beat) SHALL be handled identically; the first beat carries rlast.
REQ-031 Beats with m_axi_rvalid=1 outside DATA SHALL be ignored (rready=0).
REQ-032 m_axi_* address outputs SHALL be 0 when not in ADDR.

Reset
REQ-033 rst asserted at any time, including mid-burst, SHALL immediately force IDLE, busy=0, grant_id=0, all valid/ready outputs 0, all data/address outputs 0.
REQ-034 Last-grant pointer SHALL reset to 1 so requester 0 wins the first contended arbitration.
REQ-035 After rst deasserts, the first arbitration SHALL occur on the first edge with rst low.

Verification
REQ-036 Both arvalid high from reset, arlen=3 each -> requester 0 gets 4 beats, then requester 1 gets 4 beats; grant_id 0 then 1.
REQ-037 Only requester 1 requests, araddr=0x0000_1000, arlen=0 -> m_axi_araddr=0x1000 one cycle after request; single beat with rlast routed to s1 only.
REQ-038 m_axi_arready held low 5 cycles in ADDR, requester 0 drops no signals -> arready[0]=0 for 5 cycles, grant unchanged, requester 1 arvalid ignored.
REQ-039 s_axi_rready[grant] toggled 1/0 during 8-beat burst -> m_axi_rready mirrors it; 8 beats delivered in order, no loss or duplication.
REQ-040 rst pulsed during beat 2 of 4 -> outputs 0 asynchronously, busy=0; next contended request after reset granted to requester 0.
REQ-041 Requester 0 back-to-back requests with requester 1 continuously requesting -> strict alternation 0,1,0,1 over 4 bursts.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Bundle of the two requester-facing AXI read ports and the shared slave-facing read port.
// The "slave" modport is the arbiter's view; "master" is the environment's view.
interface axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0][ADDR_WIDTH-1:0] s_axi_araddr;
    logic [1:0][7:0]            s_axi_arlen;
    logic [1:0][2:0]            s_axi_arsize;
    logic [1:0][1:0]            s_axi_arburst;
    logic [1:0]                 s_axi_arvalid;
    logic [1:0]                 s_axi_arready;
    logic [1:0][DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0][1:0]            s_axi_rresp;
    logic [1:0]                 s_axi_rlast;
    logic [1:0]                 s_axi_rvalid;
    logic [1:0]                 s_axi_rready;

    logic [ADDR_WIDTH-1:0]      m_axi_araddr;
    logic [7:0]                 m_axi_arlen;
    logic [2:0]                 m_axi_arsize;
    logic [1:0]                 m_axi_arburst;
    logic                       m_axi_arvalid;
    logic                       m_axi_arready;
    logic [DATA_WIDTH-1:0]      m_axi_rdata;
    logic [1:0]                 m_axi_rresp;
    logic                       m_axi_rlast;
    logic                       m_axi_rvalid;
    logic                       m_axi_rready;

    modport slave (
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready
    );

    modport master (
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant, one outstanding burst at a time,
// grant held from address phase through the last data beat.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_read_arbiter_if.slave   bus,
    output logic                grant_id,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;    // requester 0 wins the first contended round
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;

        bus.s_axi_arready = '0;
        bus.s_axi_rdata   = '0;
        bus.s_axi_rresp   = '0;
        bus.s_axi_rlast   = '0;
        bus.s_axi_rvalid  = '0;
        bus.m_axi_araddr  = '0;
        bus.m_axi_arlen   = '0;
        bus.m_axi_arsize  = '0;
        bus.m_axi_arburst = '0;
        bus.m_axi_arvalid = 1'b0;
        bus.m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.s_axi_arvalid) begin
                    grant_d = (&bus.s_axi_arvalid) ? ~last_q : bus.s_axi_arvalid[1];
                    last_d  = grant_d;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.m_axi_araddr           = ADDR_WIDTH'(bus.s_axi_araddr[grant_q]);
                bus.m_axi_arlen            = bus.s_axi_arlen[grant_q];
                bus.m_axi_arsize           = bus.s_axi_arsize[grant_q];
                bus.m_axi_arburst          = bus.s_axi_arburst[grant_q];
                bus.m_axi_arvalid          = bus.s_axi_arvalid[grant_q];
                bus.s_axi_arready[grant_q] = bus.m_axi_arready;
                if (bus.s_axi_arvalid[grant_q] && bus.m_axi_arready)
                    state_d = DATA;
            end
            DATA: begin
                bus.s_axi_rdata[grant_q]  = DATA_WIDTH'(bus.m_axi_rdata);
                bus.s_axi_rresp[grant_q]  = bus.m_axi_rresp;
                bus.s_axi_rlast[grant_q]  = bus.m_axi_rlast;
                bus.s_axi_rvalid[grant_q] = bus.m_axi_rvalid;
                bus.m_axi_rready          = bus.s_axi_rready[grant_q];
                if (bus.m_axi_rvalid && bus.s_axi_rready[grant_q] && bus.m_axi_rlast)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomised bench for axi_read_arbiter: transaction-level ownership model checked every
// cycle, end-to-end beat scoreboard per requester, and directed scenarios with literal results.
module tb_axi_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic grant_id, busy;

    axi_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ownership model: who owns the shared port and in which phase
    int m_owner = -1;
    bit m_data  = 1'b0;
    int m_last  = 1;
    int gq[$];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_owner = -1; m_data = 1'b0; m_last = 1;
        end else if (m_owner < 0) begin
            if (bus.s_axi_arvalid != 2'b00) begin
                if (bus.s_axi_arvalid == 2'b11) m_owner = 1 - m_last;
                else                            m_owner = bus.s_axi_arvalid[1] ? 1 : 0;
                m_last = m_owner;
                m_data = 1'b0;
                gq.push_back(m_owner);
            end
        end else if (!m_data) begin
            if (bus.s_axi_arvalid[m_owner] && bus.m_axi_arready) m_data = 1'b1;
        end else if (bus.m_axi_rvalid && bus.s_axi_rready[m_owner] && bus.m_axi_rlast) begin
            m_owner = -1;
        end
    end

    // ---------------- per-cycle output check against the model
    logic [47:0] ea, aa;
    logic [2:0]  er, ar;
    initial forever begin
        @(negedge clk);
        ea = '0; er = '0;
        if (m_owner >= 0 && !m_data)
            ea = {bus.s_axi_araddr[m_owner], bus.s_axi_arlen[m_owner], bus.s_axi_arsize[m_owner],
                  bus.s_axi_arburst[m_owner], bus.s_axi_arvalid[m_owner],
                  (2'(bus.m_axi_arready) << m_owner)};
        aa = {bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst,
              bus.m_axi_arvalid, bus.s_axi_arready};
        chk("ar_path", 64'(aa), 64'(ea));
        if (m_owner >= 0 && m_data) begin
            er = {(2'(bus.m_axi_rvalid) << m_owner), bus.s_axi_rready[m_owner]};
            chk("r_data", 64'({bus.s_axi_rdata[m_owner], bus.s_axi_rresp[m_owner], bus.s_axi_rlast[m_owner]}),
                64'({bus.m_axi_rdata, bus.m_axi_rresp, bus.m_axi_rlast}));
        end
        ar = {bus.s_axi_rvalid, bus.m_axi_rready};
        chk("r_path", 64'(ar), 64'(er));
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        if (m_owner >= 0)  chk("grant", 64'(grant_id), 64'(m_owner));
        else if (rst)      chk("grant_rst", 64'(grant_id), 64'd0);
    end

    // ---------------- environment: two requesters + one slave
    logic [1:0] req_en = '0;
    int fix_len = -1;
    bit use_fix = 1'b0;
    logic [31:0] fix_addr = '0;
    int p_arready = 100, p_rvalid = 100, p_rready = 100, p_junk = 20;
    bit rmode = 1'b0, tog = 1'b0;

    bit pend[2];
    logic [31:0] r_addr[2];
    int r_len[2];
    logic [31:0] eq_addr[2][$];
    int eq_len[2][$];
    int rxb[2];
    int rx_beats[2];
    bit s_ar_hs[2];
    bit m_ar_hs, m_r_hs;
    logic [31:0] cap_addr;
    int cap_len;
    bit sl_act = 1'b0;
    int sl_len, sl_beat;
    logic [31:0] sl_addr;
    int dq[$];

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic env_clear();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; eq_addr[i].delete(); eq_len[i].delete(); rxb[i] = 0; s_ar_hs[i] = 1'b0;
        end
        m_ar_hs = 1'b0; m_r_hs = 1'b0; sl_act = 1'b0;
    endtask

    task automatic env_sample();
        for (int i = 0; i < 2; i++) begin
            s_ar_hs[i] = bus.s_axi_arvalid[i] && bus.s_axi_arready[i];
            if (bus.s_axi_rvalid[i] && bus.s_axi_rready[i]) begin
                if (eq_addr[i].size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rx%0d_unexpected: got beat 0x%0h expected none", i, bus.s_axi_rdata[i]);
                end else begin
                    chk($sformatf("rx%0d_beat", i), 64'({bus.s_axi_rlast[i], bus.s_axi_rdata[i]}),
                        64'({(rxb[i] == eq_len[i][0]), eq_addr[i][0] + 32'(rxb[i])}));
                    if (rxb[i] == eq_len[i][0]) begin
                        void'(eq_addr[i].pop_front()); void'(eq_len[i].pop_front()); rxb[i] = 0;
                    end else rxb[i]++;
                end
                rx_beats[i]++;
            end
        end
        m_ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
        cap_addr = bus.m_axi_araddr;
        cap_len = int'(bus.m_axi_arlen);
        if (m_ar_hs) dq.push_back(int'(grant_id));
        m_r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
    endtask

    task automatic env_update();
        if (rst) env_clear();
        else begin
            if (m_r_hs && sl_act) begin
                if (sl_beat == sl_len) sl_act = 1'b0; else sl_beat++;
            end
            if (m_ar_hs) begin
                sl_act = 1'b1; sl_len = cap_len; sl_beat = 0; sl_addr = cap_addr;
            end
            for (int i = 0; i < 2; i++) begin
                if (s_ar_hs[i]) begin
                    pend[i] = 1'b0; eq_addr[i].push_back(r_addr[i]); eq_len[i].push_back(r_len[i]);
                end
                if (!pend[i] && req_en[i]) begin
                    pend[i] = 1'b1;
                    r_addr[i] = use_fix ? fix_addr : ($urandom & 32'hFFFF_FF00);
                    r_len[i] = (fix_len < 0) ? $urandom_range(0, 7) : fix_len;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            bus.s_axi_arvalid[i] = pend[i];
            bus.s_axi_araddr[i]  = r_addr[i];
            bus.s_axi_arlen[i]   = 8'(r_len[i]);
            bus.s_axi_arsize[i]  = 3'd2;
            bus.s_axi_arburst[i] = 2'd1;
            bus.s_axi_rready[i]  = rmode ? ~tog : pct(p_rready);
        end
        tog = ~tog;
        bus.m_axi_arready = pct(p_arready);
        if (sl_act) begin
            bus.m_axi_rvalid = pct(p_rvalid);
            bus.m_axi_rdata  = sl_addr + 32'(sl_beat);
            bus.m_axi_rlast  = (sl_beat == sl_len);
            bus.m_axi_rresp  = 2'(sl_beat);
        end else begin
            bus.m_axi_rvalid = pct(p_junk);     // stray beats the arbiter must not accept
            bus.m_axi_rdata  = $urandom;
            bus.m_axi_rlast  = 1'($urandom_range(0, 1));
            bus.m_axi_rresp  = 2'd0;
        end
    endtask

    initial begin
        env_clear();
        for (int i = 0; i < 2; i++) begin r_addr[i] = '0; r_len[i] = 0; rx_beats[i] = 0; end
        bus.s_axi_arvalid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
        bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_rready = '0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = '0;
        forever begin
            @(negedge clk); env_sample();
            @(posedge clk); #1; env_update();
        end
    end

    // ---------------- directed sequences
    task automatic issue(input logic [1:0] mask);
        req_en = mask;
        @(posedge clk); #2;
        req_en = 2'b00;
    endtask

    task automatic drain();
        req_en = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (!pend[0] && !pend[1] && !busy && !sl_act) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout: got busy=%0d expected idle", busy);
    endtask

    function automatic int dqa(input int k);
        return (k < dq.size()) ? dq[k] : -1;
    endfunction

    int b0, b1, d0;
    bit ok;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_outs", 64'({bus.s_axi_arready, bus.s_axi_rvalid, bus.m_axi_arvalid, bus.m_axi_rready}), 64'd0);
        rst = 1'b0;

        // contended start, 4 beats each: 0 then 1
        fix_len = 3;
        issue(2'b11);
        drain();
        chk("t1_dq0", 64'(dqa(0)), 64'd0);
        chk("t1_dq1", 64'(dqa(1)), 64'd1);
        chk("t1_model_g0", 64'(gq[0]), 64'd0);
        chk("t1_model_g1", 64'(gq[1]), 64'd1);
        chk("t1_beats0", 64'(rx_beats[0]), 64'd4);
        chk("t1_beats1", 64'(rx_beats[1]), 64'd4);

        // single-beat request from requester 1 only
        b0 = rx_beats[0]; b1 = rx_beats[1];
        fix_len = 0; use_fix = 1'b1; fix_addr = 32'h0000_1000;
        req_en = 2'b10; @(posedge clk); #2; req_en = 2'b00;
        @(negedge clk);
        chk("t2_no_comb_path", 64'(bus.m_axi_arvalid), 64'd0);
        @(negedge clk);
        chk("t2_araddr", 64'({bus.m_axi_arvalid, bus.m_axi_araddr}), 64'({1'b1, 32'h0000_1000}));
        chk("t2_grant", 64'(grant_id), 64'd1);
        drain();
        use_fix = 1'b0;
        chk("t2_beats1", 64'(rx_beats[1] - b1), 64'd1);
        chk("t2_beats0", 64'(rx_beats[0] - b0), 64'd0);

        // slave stalls address phase; requester 1 arrives late and must wait
        fix_len = 1; p_arready = 0; d0 = dq.size();
        issue(2'b01);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = busy; end
        chk("t3_busy", 64'(ok), 64'd1);
        issue(2'b10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_arready", 64'(bus.s_axi_arready), 64'd0);
            chk("t3_grant", 64'(grant_id), 64'd0);
        end
        p_arready = 100;
        drain();
        chk("t3_dq_a", 64'(dqa(d0)), 64'd0);
        chk("t3_dq_b", 64'(dqa(d0 + 1)), 64'd1);

        // 8-beat burst with toggling rready
        fix_len = 7; rmode = 1'b1; b0 = rx_beats[0];
        issue(2'b01);
        drain();
        rmode = 1'b0;
        chk("t4_beats0", 64'(rx_beats[0] - b0), 64'd8);

        // reset during a 4-beat burst
        fix_len = 3; b0 = rx_beats[0];
        issue(2'b01);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #1; ok = (rx_beats[0] - b0) >= 2; end
        chk("t5_two_beats", 64'(ok), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_grant", 64'(grant_id), 64'd0);
        chk("t5_outs", 64'({bus.s_axi_arready, bus.s_axi_rvalid, bus.m_axi_arvalid, bus.m_axi_rready}), 64'd0);
        chk("t5_data", 64'({bus.s_axi_rdata[0], bus.m_axi_araddr}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fix_len = 0; d0 = dq.size();
        issue(2'b11);
        drain();
        chk("t5_regrant", 64'(dqa(d0)), 64'd0);

        // continuous contention: strict alternation
        fix_len = -1; d0 = dq.size();
        req_en = 2'b11;
        for (int k = 0; k < 4000 && dq.size() < d0 + 4; k++) @(negedge clk);
        drain();
        for (int k = 0; k < 4; k++) chk($sformatf("t6_alt%0d", k), 64'(dqa(d0 + k)), 64'(k % 2));

        // random soak
        p_arready = 60; p_rvalid = 70; p_rready = 70; p_junk = 30;
        for (int k = 0; k < 1500; k++) begin
            if (k % 40 == 0) req_en = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        drain();
        chk("sb_empty", 64'(eq_addr[0].size() + eq_addr[1].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
